// File: rtl/output_row_writer_if.sv
// ---------------------------------------------------------------------------
// output_row_writer_if
// Purpose : bundles the run control, result-bit stream and output SRAM write
//           port of output_row_writer.
// Signals :
//   run_start, run_end        run control pulses (master -> slave)
//   bit_valid, bit_in         conv result bit stream (master -> slave)
//   row_commit, frame_done    row control pulses (master -> slave)
//   dut_sram_write_address    12-bit SRAM word address (slave -> master)
//   dut_sram_write_data       16-bit packed row (slave -> master)
//   dut_sram_write_enable     write strobe (slave -> master)
//   busy, overflow            status (slave -> master)
// Modports: master = stimulus/controller side, slave = output_row_writer.
// ---------------------------------------------------------------------------
interface output_row_writer_if;
  logic        run_start;
  logic        run_end;
  logic        bit_valid;
  logic        bit_in;
  logic        row_commit;
  logic        frame_done;
  logic [11:0] dut_sram_write_address;
  logic [15:0] dut_sram_write_data;
  logic        dut_sram_write_enable;
  logic        busy;
  logic        overflow;

  modport master (
    output run_start, run_end, bit_valid, bit_in, row_commit, frame_done,
    input  dut_sram_write_address, dut_sram_write_data, dut_sram_write_enable,
    input  busy, overflow
  );

  modport slave (
    input  run_start, run_end, bit_valid, bit_in, row_commit, frame_done,
    output dut_sram_write_address, dut_sram_write_data, dut_sram_write_enable,
    output busy, overflow
  );
endinterface

// File: rtl/output_row_writer.sv
// ---------------------------------------------------------------------------
// output_row_writer
// Purpose : collects single conv result bits into a 16-bit row and writes
//           each committed row to consecutive words of the output SRAM.
// Ports   :
//   clk      rising-edge clock
//   reset_b  synchronous active-high reset
//   bus      output_row_writer_if.slave (run control, bit stream, SRAM
//            write port, busy/overflow status)
// Config  : define ROW_MSB_FIRST_EN to pack column k at bit [15-k] instead of
//           bit [k].
// ---------------------------------------------------------------------------
module output_row_writer (
  input  logic                 clk,
  input  logic                 reset_b,
  output_row_writer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2
  } state_t;

  state_t      state_r;
  logic [11:0] addr_r;
  logic [15:0] data_r;
  logic        we_r;
  logic        busy_r;
  logic        overflow_r;
  logic [15:0] row_r;
  logic [4:0]  count_r;
  logic        end_pending_r;   // run_end arrived together with row_commit

  logic [15:0] row_ins_s;
  logic [4:0]  count_ins_s;
  logic        ovf_hit_s;

  // Bit position of output column col inside the packed row.
  function automatic logic [3:0] col_pos(input logic [3:0] col);
`ifdef ROW_MSB_FIRST_EN
    col_pos = 4'd15 - col;
`else
    col_pos = col;
`endif
  endfunction

  // Row/count as they would be after accepting this cycle's bit (if any).
  always_comb begin
    row_ins_s   = row_r;
    count_ins_s = count_r;
    ovf_hit_s   = 1'b0;
    if (bus.bit_valid) begin
      if (count_r < 5'd16) begin
        row_ins_s[col_pos(count_r[3:0])] = bus.bit_in;
        count_ins_s                      = count_r + 5'd1;
      end else begin
        ovf_hit_s = 1'b1;
      end
    end else begin
      ovf_hit_s = 1'b0;
    end
  end

  // Control FSM with registered SRAM port and status outputs.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      state_r       <= ST_IDLE;
      addr_r        <= 12'h000;
      data_r        <= 16'h0000;
      we_r          <= 1'b0;
      busy_r        <= 1'b0;
      overflow_r    <= 1'b0;
      row_r         <= 16'h0000;
      count_r       <= 5'd0;
      end_pending_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          we_r <= 1'b0;
          if (bus.run_start) begin
            state_r       <= ST_COLLECT;
            busy_r        <= 1'b1;
            addr_r        <= 12'h000;
            row_r         <= 16'h0000;
            count_r       <= 5'd0;
            overflow_r    <= 1'b0;
            end_pending_r <= 1'b0;
          end else begin
            busy_r <= 1'b0;
          end
        end

        ST_COLLECT: begin
          if (ovf_hit_s) begin
            overflow_r <= 1'b1;
          end
          if (bus.row_commit) begin
            // The bit offered alongside the commit belongs to this row.
            state_r       <= ST_WRITE;
            we_r          <= 1'b1;
            data_r        <= row_ins_s;
            row_r         <= row_ins_s;
            count_r       <= count_ins_s;
            end_pending_r <= bus.run_end;
            busy_r        <= 1'b1;
          end else if (bus.run_end) begin
            state_r <= ST_IDLE;
            we_r    <= 1'b0;
            busy_r  <= 1'b0;
          end else if (bus.frame_done) begin
            we_r    <= 1'b0;
            row_r   <= 16'h0000;
            count_r <= 5'd0;
          end else begin
            we_r    <= 1'b0;
            row_r   <= row_ins_s;
            count_r <= count_ins_s;
          end
        end

        ST_WRITE: begin
          // Single write cycle; address wraps naturally at 12 bits.
          we_r          <= 1'b0;
          addr_r        <= addr_r + 12'd1;
          row_r         <= 16'h0000;
          count_r       <= 5'd0;
          end_pending_r <= 1'b0;
          if (bus.run_end || end_pending_r) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_COLLECT;
            busy_r  <= 1'b1;
          end
        end

        default: begin
          state_r       <= ST_IDLE;
          we_r          <= 1'b0;
          busy_r        <= 1'b0;
          row_r         <= 16'h0000;
          count_r       <= 5'd0;
          end_pending_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dut_sram_write_address = addr_r;
  assign bus.dut_sram_write_data    = data_r;
  assign bus.dut_sram_write_enable  = we_r;
  assign bus.busy                   = busy_r;
  assign bus.overflow               = overflow_r;

endmodule

// File: tb/tb_output_row_writer.sv
// ---------------------------------------------------------------------------
// tb_output_row_writer
// Purpose : directed self-checking bench for output_row_writer. Inputs are
//           driven 1 time unit after each rising edge and outputs are sampled
//           at that same point, so each check sees the state produced by the
//           preceding edge.
// ---------------------------------------------------------------------------
module tb_output_row_writer;

  logic clk;
  logic reset_b;
  int   n_cmp;
  int   n_err;

  output_row_writer_if bus ();

  output_row_writer dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

`ifdef ROW_MSB_FIRST_EN
  localparam logic [15:0] EXP_1011 = 16'hB000;
  localparam logic [15:0] EXP_001  = 16'h2000;
  localparam logic [15:0] EXP_1    = 16'h8000;
`else
  localparam logic [15:0] EXP_1011 = 16'h000D;
  localparam logic [15:0] EXP_001  = 16'h0004;
  localparam logic [15:0] EXP_1    = 16'h0001;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    step();
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
  endtask

  task automatic pulse_commit();
    bus.row_commit = 1'b1;
    step();
    bus.row_commit = 1'b0;
  endtask

  task automatic pulse_start();
    bus.run_start = 1'b1;
    step();
    bus.run_start = 1'b0;
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    reset_b        = 1'b1;
    bus.run_start  = 1'b0;
    bus.run_end    = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.bit_in     = 1'b0;
    bus.row_commit = 1'b0;
    bus.frame_done = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_addr", {4'h0, bus.dut_sram_write_address}, 16'h0000);
    chk("rst_data", bus.dut_sram_write_data, 16'h0000);
    chk("rst_we",   {15'd0, bus.dut_sram_write_enable}, 16'h0000);
    chk("rst_busy", {15'd0, bus.busy}, 16'h0000);
    chk("rst_ovf",  {15'd0, bus.overflow}, 16'h0000);
    reset_b = 1'b0;
    step();

    // Commit in IDLE is ignored
    pulse_commit();
    chk("idle_commit_we", {15'd0, bus.dut_sram_write_enable}, 16'h0000);

    pulse_start();
    chk("start_busy", {15'd0, bus.busy}, 16'h0001);

    // Bits 1,0,1,1 then commit
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    pulse_commit();
    chk("r1_we",   {15'd0, bus.dut_sram_write_enable}, 16'h0001);
    chk("r1_addr", {4'h0, bus.dut_sram_write_address}, 16'h0000);
    chk("r1_data", bus.dut_sram_write_data, EXP_1011);
    step();
    chk("r1_we_off",  {15'd0, bus.dut_sram_write_enable}, 16'h0000);
    chk("r1_addr_nx", {4'h0, bus.dut_sram_write_address}, 16'h0001);
    chk("r1_data_hold", bus.dut_sram_write_data, EXP_1011);
    chk("r1_busy", {15'd0, bus.busy}, 16'h0001);

    // Two zeros, then a one in the commit cycle
    send_bit(1'b0);
    send_bit(1'b0);
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    pulse_commit();
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    chk("r2_data", bus.dut_sram_write_data, EXP_001);
    chk("r2_addr", {4'h0, bus.dut_sram_write_address}, 16'h0001);
    step();

    // 17 ones: overflow, then full row
    for (int i = 0; i < 16; i++) send_bit(1'b1);
    chk("ovf_not_yet", {15'd0, bus.overflow}, 16'h0000);
    send_bit(1'b1);
    chk("ovf_set", {15'd0, bus.overflow}, 16'h0001);
    pulse_commit();
    chk("r3_data", bus.dut_sram_write_data, 16'hFFFF);
    chk("r3_addr", {4'h0, bus.dut_sram_write_address}, 16'h0002);
    step();
    chk("ovf_sticky", {15'd0, bus.overflow}, 16'h0001);

    // Three bits discarded by frame_done, then empty commit
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    bus.frame_done = 1'b1;
    step();
    bus.frame_done = 1'b0;
    chk("fd_addr", {4'h0, bus.dut_sram_write_address}, 16'h0003);
    pulse_commit();
    chk("fd_we",   {15'd0, bus.dut_sram_write_enable}, 16'h0001);
    chk("fd_data", bus.dut_sram_write_data, 16'h0000);
    step();

    // row_commit wins over frame_done
    send_bit(1'b1);
    bus.frame_done = 1'b1;
    pulse_commit();
    bus.frame_done = 1'b0;
    chk("fdc_data", bus.dut_sram_write_data, EXP_1);
    chk("fdc_addr", {4'h0, bus.dut_sram_write_address}, 16'h0004);
    step();

    // run_start outside IDLE is ignored
    pulse_start();
    chk("restart_addr", {4'h0, bus.dut_sram_write_address}, 16'h0005);
    chk("restart_ovf",  {15'd0, bus.overflow}, 16'h0001);

    // run_end in COLLECT
    bus.run_end = 1'b1;
    step();
    bus.run_end = 1'b0;
    chk("end_busy", {15'd0, bus.busy}, 16'h0000);
    step();
    chk("idle_addr_hold", {4'h0, bus.dut_sram_write_address}, 16'h0005);

    // New run clears address and overflow
    pulse_start();
    chk("run2_addr", {4'h0, bus.dut_sram_write_address}, 16'h0000);
    chk("run2_ovf",  {15'd0, bus.overflow}, 16'h0000);

    // 4095 commits, then write at 0xFFF and wrap
    for (int i = 0; i < 4095; i++) begin
      pulse_commit();
      step();
    end
    chk("pre_wrap_addr", {4'h0, bus.dut_sram_write_address}, 16'h0FFF);
    send_bit(1'b1);
    pulse_commit();
    chk("wrap_we",   {15'd0, bus.dut_sram_write_enable}, 16'h0001);
    chk("wrap_addr", {4'h0, bus.dut_sram_write_address}, 16'h0FFF);
    chk("wrap_data", bus.dut_sram_write_data, EXP_1);
    step();
    chk("wrap_addr_nx", {4'h0, bus.dut_sram_write_address}, 16'h0000);

    // Reset during WRITE
    pulse_commit();
    chk("rw_we_pre", {15'd0, bus.dut_sram_write_enable}, 16'h0001);
    reset_b = 1'b1;
    step();
    reset_b = 1'b0;
    chk("rw_we",   {15'd0, bus.dut_sram_write_enable}, 16'h0000);
    chk("rw_addr", {4'h0, bus.dut_sram_write_address}, 16'h0000);
    chk("rw_busy", {15'd0, bus.busy}, 16'h0000);

    // run_end during WRITE completes the write then idles
    pulse_start();
    pulse_commit();
    chk("ew_we", {15'd0, bus.dut_sram_write_enable}, 16'h0001);
    bus.run_end = 1'b1;
    step();
    bus.run_end = 1'b0;
    chk("ew_busy", {15'd0, bus.busy}, 16'h0000);
    chk("ew_addr", {4'h0, bus.dut_sram_write_address}, 16'h0001);
    chk("ew_we_off", {15'd0, bus.dut_sram_write_enable}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/output_row_writer.md
OUTPUT_ROW_WRITER -- requirements
Module: output_row_writer

Interface
- REQ-001: clk  input  1  rising-edge clock; the only clock.
- REQ-002: reset_b  input  1  synchronous active-high reset, sampled on the rising edge of clk.
- REQ-003: run_start  input  1  single-cycle pulse that begins a run.
- REQ-004: run_end  input  1  single-cycle pulse that ends a run after any pending write.
- REQ-005: bit_valid  input  1  conv result bit present this cycle.
- REQ-006: bit_in  input  1  conv result bit for the next output column.
- REQ-007: row_commit  input  1  pulse; write the collected row to output SRAM.
- REQ-008: frame_done  input  1  pulse; discard any partial row at the end of a matrix.
- REQ-009: dut_sram_write_address  output  12  output SRAM word address.
- REQ-010: dut_sram_write_data  output  16  packed output row.
- REQ-011: dut_sram_write_enable  output  1  write strobe.
- REQ-012: busy  output  1  high in COLLECT or WRITE.
- REQ-013: overflow  output  1  sticky; more than 16 bits were offered in one row.

Function
- REQ-014: The FSM SHALL have three states: IDLE, COLLECT and WRITE.
- REQ-015: In IDLE, run_start SHALL select COLLECT, clear the write address to 0x000 and clear the row register, bit count and overflow; all other inputs are ignored in IDLE.
- REQ-016: In COLLECT, bit_valid with count<16 SHALL store bit_in at row bit [count] and increment count (5-bit, 0..16).
- REQ-017: bit_valid with count==16 SHALL drop the bit and set overflow; overflow clears only on reset or run_start.
- REQ-018: In COLLECT, row_commit SHALL select WRITE; if bit_valid is high in the same cycle, that bit SHALL be included in the committed row.
- REQ-019: In WRITE (exactly one cycle), write_enable=1, write_address=current address, write_data=row register, with unfilled bits 0.
- REQ-020: Latency SHALL be: row_commit sampled at edge N -> write_enable high during cycle N+1 -> address incremented and row/count cleared at edge N+1, then back to COLLECT.
- REQ-021: row_commit, bit_valid and frame_done in WRITE SHALL be ignored.
- REQ-022: row_commit with count==0 SHALL still write 0x0000.
- REQ-023: frame_done in COLLECT SHALL clear the row register and count without changing the address; if row_commit is also asserted, row_commit wins.
- REQ-024: run_end in COLLECT SHALL select IDLE. run_end in WRITE SHALL complete the write and then select IDLE. The address SHALL hold its value in IDLE.
- REQ-025: The address SHALL wrap from 0xFFF to 0x000 without a flag.
- REQ-026: run_start outside IDLE SHALL be ignored.
- REQ-027: write_enable SHALL be 0 in every state except WRITE, and data/address SHALL hold their last values when write_enable is 0.

Reset
- REQ-028: Reset SHALL force IDLE, address=0x000, data=0x0000, write_enable=0, busy=0, overflow=0, row=0 and count=0.
- REQ-029: Reset mid-run, including during WRITE, SHALL abort with no write strobe in the following cycle.

Configuration
- REQ-030: With macro ROW_MSB_FIRST_EN defined, column k SHALL be packed at bit [15-k]; without it, column k SHALL be packed at bit [k]. No other behaviour changes.

Verification
- REQ-031: run_start; bits 1,0,1,1 on 4 cycles; row_commit -> next cycle we=1, addr=0x000, data=0x000D (0xB000 with ROW_MSB_FIRST_EN); addr=0x001 after.
- REQ-032: 17 bits all 1 then row_commit -> data=0xFFFF, overflow=1 and held until next run_start.
- REQ-033: bit_valid=1, bit_in=1 in the same cycle as row_commit after 2 zero bits -> data=0x0004.
- REQ-034: address preset to 0xFFF via 4095 commits; one more commit writes at 0xFFF, next address=0x000.
- REQ-035: 3 bits then frame_done, then row_commit -> data=0x0000, address unchanged by frame_done.
- REQ-036: reset_b=1 in the WRITE cycle -> next cycle we=0, addr=0x000, busy=0; run_end in WRITE -> write occurs, then busy=0.
